// File: rtl/byte_stripe_ctrl.sv
// Two-lane word striper: sends SYNC_WORDS alignment pairs, then alternates
// accepted input words between lane 0 and lane 1 behind per-lane hold registers.
module byte_stripe_ctrl #(
    parameter int          SYNC_WORDS   = 4,
    parameter logic [31:0] SYNC_PATTERN = 32'hBCBCBCBC
) (
    input  logic        clk_2f,
    input  logic        reset,
    input  logic        enable,
    input  logic        valid_in,
    input  logic [31:0] data_in,
    output logic        ready_out,
    input  logic        lane_ready_0,
    input  logic        lane_ready_1,
    output logic        valid_0,
    output logic        valid_1,
    output logic [31:0] lane_0,
    output logic [31:0] lane_1,
    output logic [1:0]  state,
    output logic [7:0]  words_0,
    output logic [7:0]  words_1
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SYNC   = 2'd1,
        ACTIVE = 2'd2,
        DRAIN  = 2'd3
    } state_t;

    state_t      state_reg;
    logic [3:0]  sync_cnt_reg;
    logic        ptr_reg;
    logic [1:0]  valid_reg;
    logic [31:0] lane_reg  [2];
    logic [7:0]  words_reg [2];

    logic [1:0]  lane_ready;
    logic [1:0]  free;
    logic [1:0]  load;
    logic        sync_load;
    logic        sync_done;
    logic        xfer;

    assign lane_ready = {lane_ready_1, lane_ready_0};

    // Sync pairs only go out when both lanes can take a word in the same cycle.
    assign sync_load = (state_reg == SYNC) && enable && (&free);
    assign sync_done = sync_load && (sync_cnt_reg == 4'(SYNC_WORDS - 1));
    assign ready_out = (state_reg == ACTIVE) && free[ptr_reg];
    assign xfer      = valid_in && ready_out;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_lane
            assign free[gi] = !valid_reg[gi] || lane_ready[gi];
            assign load[gi] = sync_load || (xfer && (ptr_reg == 1'(gi)));

            always_ff @(posedge clk_2f or posedge reset) begin
                if (reset) begin
                    valid_reg[gi] <= 1'b0;
                    lane_reg[gi]  <= '0;
                    words_reg[gi] <= '0;
                end else begin
                    if (load[gi]) begin
                        lane_reg[gi]  <= sync_load ? SYNC_PATTERN : data_in;
                        valid_reg[gi] <= 1'b1;
                    end else if (lane_ready[gi]) begin
                        valid_reg[gi] <= 1'b0;
                    end
                    // Counters restart when the link goes active; sync words never count.
                    if (sync_done)
                        words_reg[gi] <= '0;
                    else if (xfer && (ptr_reg == 1'(gi)))
                        words_reg[gi] <= words_reg[gi] + 8'd1;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk_2f or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            sync_cnt_reg <= '0;
            ptr_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (enable && (&free)) begin
                        state_reg    <= SYNC;
                        sync_cnt_reg <= '0;
                    end
                end
                SYNC: begin
                    if (!enable) begin
                        state_reg <= IDLE;
                    end else if (sync_load) begin
                        sync_cnt_reg <= sync_cnt_reg + 4'd1;
                        if (sync_done) begin
                            state_reg <= ACTIVE;
                            ptr_reg   <= 1'b0;
                        end
                    end
                end
                ACTIVE: begin
                    if (xfer)
                        ptr_reg <= ~ptr_reg;
                    if (!enable)
                        state_reg <= DRAIN;
                end
                DRAIN: begin
                    if (valid_reg == 2'b00)
                        state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign state   = state_reg;
    assign valid_0 = valid_reg[0];
    assign valid_1 = valid_reg[1];
    assign lane_0  = lane_reg[0];
    assign lane_1  = lane_reg[1];
    assign words_0 = words_reg[0];
    assign words_1 = words_reg[1];

endmodule

// File: tb/tb_byte_stripe_ctrl.sv
// Directed, table-driven bench for byte_stripe_ctrl with hand-computed expectations,
// plus hand sequences for counter wrap, asynchronous reset and SYNC abort.
module tb_byte_stripe_ctrl;

    logic        clk_2f = 1'b0;
    logic        reset;
    logic        enable;
    logic        valid_in;
    logic [31:0] data_in;
    logic        ready_out;
    logic        lane_ready_0;
    logic        lane_ready_1;
    logic        valid_0;
    logic        valid_1;
    logic [31:0] lane_0;
    logic [31:0] lane_1;
    logic [1:0]  state;
    logic [7:0]  words_0;
    logic [7:0]  words_1;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk_2f = ~clk_2f;

    byte_stripe_ctrl dut (
        .clk_2f       (clk_2f),
        .reset        (reset),
        .enable       (enable),
        .valid_in     (valid_in),
        .data_in      (data_in),
        .ready_out    (ready_out),
        .lane_ready_0 (lane_ready_0),
        .lane_ready_1 (lane_ready_1),
        .valid_0      (valid_0),
        .valid_1      (valid_1),
        .lane_0       (lane_0),
        .lane_1       (lane_1),
        .state        (state),
        .words_0      (words_0),
        .words_1      (words_1)
    );

    typedef struct {
        logic        en;
        logic        vin;
        logic [31:0] din;
        logic        lr0;
        logic        lr1;
        logic        rdy;
        logic [1:0]  st;
        logic        v0;
        logic        v1;
        logic [31:0] l0;
        logic [31:0] l1;
        logic [7:0]  w0;
        logic [7:0]  w1;
    } vec_t;

    localparam int NV = 22;
    vec_t vecs [NV];

    function automatic vec_t mk(logic en, logic vin, logic [31:0] din, logic lr0, logic lr1,
                                logic rdy, logic [1:0] st, logic v0, logic v1,
                                logic [31:0] l0, logic [31:0] l1, logic [7:0] w0, logic [7:0] w1);
        vec_t r;
        r.en = en; r.vin = vin; r.din = din; r.lr0 = lr0; r.lr1 = lr1;
        r.rdy = rdy; r.st = st; r.v0 = v0; r.v1 = v1;
        r.l0 = l0; r.l1 = l1; r.w0 = w0; r.w1 = w1;
        return r;
    endfunction

    task automatic check_rdy(input string name, input logic exp);
        n_vec++;
        if (ready_out !== exp) begin
            n_bad++;
            $display("FAIL %s ready_out got %b want %b", name, ready_out, exp);
        end else
            $display("ok   %s ready_out=%b", name, ready_out);
    endtask

    task automatic check_out(input string name, input logic [1:0] st, input logic v0, input logic v1,
                             input logic [31:0] l0, input logic [31:0] l1,
                             input logic [7:0] w0, input logic [7:0] w1);
        logic bad;
        n_vec++;
        bad = 1'b0;
        if (state !== st)   begin bad = 1'b1; $display("FAIL %s state got %0d want %0d", name, state, st); end
        if (valid_0 !== v0) begin bad = 1'b1; $display("FAIL %s valid_0 got %b want %b", name, valid_0, v0); end
        if (valid_1 !== v1) begin bad = 1'b1; $display("FAIL %s valid_1 got %b want %b", name, valid_1, v1); end
        if (lane_0 !== l0)  begin bad = 1'b1; $display("FAIL %s lane_0 got %h want %h", name, lane_0, l0); end
        if (lane_1 !== l1)  begin bad = 1'b1; $display("FAIL %s lane_1 got %h want %h", name, lane_1, l1); end
        if (words_0 !== w0) begin bad = 1'b1; $display("FAIL %s words_0 got %0d want %0d", name, words_0, w0); end
        if (words_1 !== w1) begin bad = 1'b1; $display("FAIL %s words_1 got %0d want %0d", name, words_1, w1); end
        if (bad) n_bad++;
        else $display("ok   %s st=%0d v=%b%b l0=%h l1=%h w=%0d/%0d",
                      name, state, valid_0, valid_1, lane_0, lane_1, words_0, words_1);
    endtask

    task automatic drive(input logic en, input logic vin, input logic [31:0] din,
                         input logic lr0, input logic lr1);
        enable = en; valid_in = vin; data_in = din;
        lane_ready_0 = lr0; lane_ready_1 = lr1;
    endtask

    task automatic tick();
        @(posedge clk_2f);
        #1;
    endtask

    localparam logic [31:0] BC = 32'hBCBCBCBC;

    initial begin
        // Reset/sync, round-robin, bubble, stall on lane 0, drain with held lanes.
        vecs[0]  = mk(1,0,32'h0,       1,1, 0,2'd1,0,0,32'h0,       32'h0,       8'd0,8'd0);
        vecs[1]  = mk(1,0,32'h0,       1,1, 0,2'd1,1,1,BC,          BC,          8'd0,8'd0);
        vecs[2]  = mk(1,0,32'h0,       1,1, 0,2'd1,1,1,BC,          BC,          8'd0,8'd0);
        vecs[3]  = mk(1,0,32'h0,       1,1, 0,2'd1,1,1,BC,          BC,          8'd0,8'd0);
        vecs[4]  = mk(1,0,32'h0,       1,1, 0,2'd2,1,1,BC,          BC,          8'd0,8'd0);
        vecs[5]  = mk(1,1,32'hFFFFFFFF,1,1, 1,2'd2,1,0,32'hFFFFFFFF,BC,          8'd1,8'd0);
        vecs[6]  = mk(1,1,32'h88888888,1,1, 1,2'd2,0,1,32'hFFFFFFFF,32'h88888888,8'd1,8'd1);
        vecs[7]  = mk(1,1,32'hDDDDDDDD,1,1, 1,2'd2,1,0,32'hDDDDDDDD,32'h88888888,8'd2,8'd1);
        vecs[8]  = mk(1,1,32'h77777777,1,1, 1,2'd2,0,1,32'hDDDDDDDD,32'h77777777,8'd2,8'd2);
        vecs[9]  = mk(1,0,32'h090D70F3,1,1, 1,2'd2,0,0,32'hDDDDDDDD,32'h77777777,8'd2,8'd2);
        vecs[10] = mk(1,1,32'h11111111,1,1, 1,2'd2,1,0,32'h11111111,32'h77777777,8'd3,8'd2);
        vecs[11] = mk(1,1,32'h22222222,0,1, 1,2'd2,1,1,32'h11111111,32'h22222222,8'd3,8'd3);
        vecs[12] = mk(1,1,32'h33333333,0,1, 0,2'd2,1,0,32'h11111111,32'h22222222,8'd3,8'd3);
        vecs[13] = mk(1,1,32'h33333333,0,1, 0,2'd2,1,0,32'h11111111,32'h22222222,8'd3,8'd3);
        vecs[14] = mk(1,1,32'h33333333,1,1, 1,2'd2,1,0,32'h33333333,32'h22222222,8'd4,8'd3);
        vecs[15] = mk(1,1,32'h44444444,0,1, 1,2'd2,1,1,32'h33333333,32'h44444444,8'd4,8'd4);
        vecs[16] = mk(0,0,32'h0,       0,0, 0,2'd3,1,1,32'h33333333,32'h44444444,8'd4,8'd4);
        vecs[17] = mk(1,0,32'h0,       0,0, 0,2'd3,1,1,32'h33333333,32'h44444444,8'd4,8'd4);
        vecs[18] = mk(1,0,32'h0,       1,0, 0,2'd3,0,1,32'h33333333,32'h44444444,8'd4,8'd4);
        vecs[19] = mk(0,0,32'h0,       0,1, 0,2'd3,0,0,32'h33333333,32'h44444444,8'd4,8'd4);
        vecs[20] = mk(0,0,32'h0,       1,1, 0,2'd0,0,0,32'h33333333,32'h44444444,8'd4,8'd4);
        vecs[21] = mk(0,0,32'h0,       1,1, 0,2'd0,0,0,32'h33333333,32'h44444444,8'd4,8'd4);

        reset = 1'b1;
        drive(0, 0, 32'h0, 0, 0);
        #12;
        check_out("reset", 2'd0, 0, 0, 32'h0, 32'h0, 8'd0, 8'd0);
        check_rdy("reset", 1'b0);
        @(posedge clk_2f);
        #1;
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].en, vecs[i].vin, vecs[i].din, vecs[i].lr0, vecs[i].lr1);
            #1;
            check_rdy($sformatf("vec%0d", i), vecs[i].rdy);
            tick();
            check_out($sformatf("vec%0d", i), vecs[i].st, vecs[i].v0, vecs[i].v1,
                      vecs[i].l0, vecs[i].l1, vecs[i].w0, vecs[i].w1);
        end

        // Restart: counters cleared on entering ACTIVE, then 300 + 220 words to wrap them.
        drive(1, 0, 32'h0, 1, 1);
        repeat (5) tick();
        check_out("restart", 2'd2, 1, 1, BC, BC, 8'd0, 8'd0);
        begin
            int n_acc;
            int miss;
            n_acc = 0;
            miss  = 0;
            for (int i = 0; i < 520; i++) begin
                drive(1, 1, 32'(i) ^ 32'hA5000000, 1, 1);
                #1;
                if (ready_out !== 1'b1) miss++;
                else n_acc++;
                tick();
                if (i == 299) begin
                    n_vec++;
                    if (words_0 !== 8'(n_acc / 2) || words_1 !== 8'(n_acc / 2)) begin
                        n_bad++;
                        $display("FAIL wrap300 words got %0d/%0d want %0d/%0d",
                                 words_0, words_1, n_acc / 2, n_acc / 2);
                    end else
                        $display("ok   wrap300 words=%0d/%0d", words_0, words_1);
                end
            end
            n_vec++;
            if (miss != 0) begin
                n_bad++;
                $display("FAIL stream ready_out low %0d cycles want 0", miss);
            end else
                $display("ok   stream ready_out held high");
            check_out("wrap520", 2'd2, 0, 1, 32'(518) ^ 32'hA5000000, 32'(519) ^ 32'hA5000000,
                      8'((520 / 2) % 256), 8'((520 / 2) % 256));
        end

        // Fill both lanes, then pulse reset between clock edges.
        drive(1, 1, 32'hCAFEF00D, 0, 0);
        tick();
        check_out("prefill", 2'd2, 1, 1, 32'hCAFEF00D, 32'(519) ^ 32'hA5000000, 8'd5, 8'd4);
        #2;
        reset = 1'b1;
        #1;
        check_out("async_rst", 2'd0, 0, 0, 32'h0, 32'h0, 8'd0, 8'd0);
        #1;
        reset = 1'b0;
        drive(0, 0, 32'h0, 1, 1);
        tick();
        tick();
        check_out("post_rst", 2'd0, 0, 0, 32'h0, 32'h0, 8'd0, 8'd0);

        // Abort during SYNC: loaded pair stays until consumed.
        drive(1, 0, 32'h0, 1, 1);
        tick();
        tick();
        check_out("sync1", 2'd1, 1, 1, BC, BC, 8'd0, 8'd0);
        drive(0, 0, 32'h0, 0, 0);
        tick();
        check_out("abort", 2'd0, 1, 1, BC, BC, 8'd0, 8'd0);
        drive(0, 0, 32'h0, 1, 1);
        tick();
        check_out("abort_drain", 2'd0, 0, 0, BC, BC, 8'd0, 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
